// File: rtl/icache_pkg.sv
// ----------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the set-associative instruction-cache storage:
//   - address-split helpers (offset / index / tag extraction from a word
//     address, zero-extended to ADDR_MAX_BITS, given the field widths)
//   - tree-PLRU bit layout (node numbering and pointer direction encoding)
//   - flush state encoding
// ----------------------------------------------------------------------------
package icache_pkg;

    // Widest word address the helpers accept; callers cast down to field width.
    localparam int unsigned ADDR_MAX_BITS = 64;
    typedef logic [ADDR_MAX_BITS-1:0] addr_wide_t;

    // Tree-PLRU layout: node 0 is the root, node n has children 2n+1 / 2n+2.
    // A node bit points towards the subtree that holds the next victim.
    localparam int unsigned PLRU_ROOT_NODE = 0;
    localparam logic        PLRU_PTR_LEFT  = 1'b0;
    localparam logic        PLRU_PTR_RIGHT = 1'b1;

    // Flush sequencer states.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } flush_state_e;

    // Node number of the p-th node (left to right) on tree level l.
    function automatic int unsigned plru_node(input int unsigned l, input int unsigned p);
        return ((32'd1 << l) - 32'd1) + PLRU_ROOT_NODE + p;
    endfunction

    // Mask with the low w bits set.
    function automatic addr_wide_t low_mask(input int unsigned w);
        addr_wide_t m;
        if (w >= ADDR_MAX_BITS) begin
            m = '1;
        end else begin
            m = (64'd1 << w) - 64'd1;
        end
        return m;
    endfunction

    // Word-within-line offset field.
    function automatic addr_wide_t get_offset(input addr_wide_t addr,
                                              input int unsigned offset_bits);
        return addr & low_mask(offset_bits);
    endfunction

    // Set index field.
    function automatic addr_wide_t get_index(input addr_wide_t addr,
                                             input int unsigned offset_bits,
                                             input int unsigned index_bits);
        return (addr >> offset_bits) & low_mask(index_bits);
    endfunction

    // Tag field: everything above index and offset.
    function automatic addr_wide_t get_tag(input addr_wide_t addr,
                                           input int unsigned offset_bits,
                                           input int unsigned index_bits);
        return addr >> (offset_bits + index_bits);
    endfunction

endpackage

// File: rtl/icache_plru.sv
// ----------------------------------------------------------------------------
// icache_plru
// Combinational tree-PLRU for one set.
//   plru_bits  in   current tree bits of the set
//   access_way in   way being touched (hit or fill)
//   plru_next  out  tree bits after marking access_way most-recent
//   victim_way out  way the current tree bits point at
// With WAYS = 1 there is no tree: plru_next is zero and the victim is way 0.
// ----------------------------------------------------------------------------
module icache_plru
    import icache_pkg::*;
#(
    parameter  int unsigned WAYS   = 2,
    localparam int unsigned PLRU_W = (WAYS > 1) ? (WAYS - 1) : 1,
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic [PLRU_W-1:0] plru_bits,
    input  logic [WAY_W-1:0]  access_way,
    output logic [PLRU_W-1:0] plru_next,
    output logic [WAY_W-1:0]  victim_way
);

    generate
        if (WAYS == 1) begin : g_single
            assign plru_next  = '0;
            assign victim_way = '0;
        end else begin : g_tree
            localparam int unsigned LVL = $clog2(WAYS);

            logic        path_ok_s;
            logic        go_right_s;
            int unsigned aw_s;

            // Victim: the one way whose whole root-to-leaf path agrees with the pointers.
            always_comb begin
                victim_way = '0;
                path_ok_s  = 1'b0;
                go_right_s = 1'b0;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    path_ok_s = 1'b1;
                    for (int unsigned l = 0; l < LVL; l++) begin
                        go_right_s = ((w >> (LVL - 1 - l)) % 2) == 1;
                        if ((plru_bits[plru_node(l, w >> (LVL - l))] == PLRU_PTR_RIGHT) != go_right_s) begin
                            path_ok_s = 1'b0;
                        end else begin
                            path_ok_s = path_ok_s;
                        end
                    end
                    if (path_ok_s) begin
                        victim_way = WAY_W'(w);
                    end else begin
                        victim_way = victim_way;
                    end
                end
            end

            // Update: every node on the accessed path points away from that path.
            always_comb begin
                plru_next = plru_bits;
                aw_s      = 32'(access_way);
                for (int unsigned l = 0; l < LVL; l++) begin
                    for (int unsigned p = 0; p < (32'd1 << l); p++) begin
                        if ((aw_s >> (LVL - l)) == p) begin
                            plru_next[plru_node(l, p)] = (((aw_s >> (LVL - 1 - l)) % 2) == 1)
                                                         ? PLRU_PTR_LEFT : PLRU_PTR_RIGHT;
                        end else begin
                            plru_next[plru_node(l, p)] = plru_bits[plru_node(l, p)];
                        end
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/icache_sa_storage.sv
// ----------------------------------------------------------------------------
// icache_sa_storage
// N-way set-associative tag/data store for the instruction cache.
//   clk, reset_n        clock, asynchronous active-low reset
//   read / address      lookup; result one cycle later on read_valid, hit,
//                       read_data (0 on miss) and hit_way, held until the
//                       next accepted lookup
//   write / write_block line fill: overwrite a matching way, else the
//                       lowest invalid way, else the PLRU victim
//   flush               starts a one-set-per-cycle sweep of valid and PLRU
//   busy                sweep in progress; read/write/flush are ignored
// Tag and data arrays are deliberately not reset; only valid bits gate hits.
// ----------------------------------------------------------------------------
module icache_sa_storage
    import icache_pkg::*;
#(
    parameter  int unsigned WAYS        = 2,
    parameter  int unsigned BLOCK_SIZE  = 4,
    parameter  int unsigned WORD_WIDTH  = 32,
    parameter  int unsigned INDEX_BITS  = 4,
    parameter  int unsigned ADDR_WIDTH  = 32,
    localparam int unsigned OFFSET_BITS = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 0,
    localparam int unsigned OFF_W       = (OFFSET_BITS > 0) ? OFFSET_BITS : 1,
    localparam int unsigned TAG_BITS    = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS,
    localparam int unsigned NUM_SETS    = 32'd1 << INDEX_BITS,
    localparam int unsigned WAY_W       = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int unsigned PLRU_W      = (WAYS > 1) ? (WAYS - 1) : 1,
    localparam int unsigned LINE_W      = WORD_WIDTH * BLOCK_SIZE
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [LINE_W-1:0]     write_block,
    input  logic                  flush,
    output logic                  read_valid,
    output logic                  hit,
    output logic [WORD_WIDTH-1:0] read_data,
    output logic [WAY_W-1:0]      hit_way,
    output logic                  busy
);

    // Sequencer and per-set state.
    flush_state_e            state_q, state_d;
    logic [INDEX_BITS-1:0]   sweep_cnt_q, sweep_cnt_d;
    logic [WAYS-1:0]         valid_q [NUM_SETS];
    logic [WAYS-1:0]         valid_d [NUM_SETS];
    logic [PLRU_W-1:0]       plru_q  [NUM_SETS];
    logic [PLRU_W-1:0]       plru_d  [NUM_SETS];

    // Unreset storage arrays.
    logic [TAG_BITS-1:0]     tag_mem  [NUM_SETS][WAYS];
    logic [LINE_W-1:0]       data_mem [NUM_SETS][WAYS];

    // Registered lookup result.
    logic                    read_valid_q;
    logic                    hit_q;
    logic [WORD_WIDTH-1:0]   read_data_q;
    logic [WAY_W-1:0]        hit_way_q;

    // Request qualification and address fields.
    logic                    idle_s;
    logic                    rd_accept_s;
    logic                    wr_accept_s;
    logic                    flush_accept_s;
    logic [INDEX_BITS-1:0]   idx_s;
    logic [TAG_BITS-1:0]     tag_s;
    logic [OFF_W-1:0]        off_s;

    // Lookup / fill selection.
    logic [WAYS-1:0]         match_s;
    logic                    hit_s;
    logic [WAY_W-1:0]        hit_way_s;
    logic                    any_invalid_s;
    logic [WAY_W-1:0]        inv_way_s;
    logic [LINE_W-1:0]       line_s;
    logic [WORD_WIDTH-1:0]   word_sel_s;
    logic [WORD_WIDTH-1:0]   rd_word_s;
    logic [WAY_W-1:0]        fill_way_s;
    logic [WAY_W-1:0]        access_way_s;
    logic [WAY_W-1:0]        victim_s;
    logic [PLRU_W-1:0]       plru_upd_s;

    assign idle_s         = (state_q == IDLE);
    assign rd_accept_s    = read  & idle_s;
    assign wr_accept_s    = write & idle_s;
    assign flush_accept_s = flush & idle_s;

    assign idx_s = INDEX_BITS'(get_index(addr_wide_t'(address), OFFSET_BITS, INDEX_BITS));
    assign tag_s = TAG_BITS'(get_tag(addr_wide_t'(address), OFFSET_BITS, INDEX_BITS));
    assign off_s = OFF_W'(get_offset(addr_wide_t'(address), OFFSET_BITS));

    // Parallel tag compare across the addressed set, plus hit word and first free way.
    always_comb begin
        match_s       = '0;
        hit_way_s     = '0;
        inv_way_s     = '0;
        word_sel_s    = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            match_s[w] = valid_q[idx_s][w] & (tag_mem[idx_s][w] == tag_s);
        end
        hit_s         = |match_s;
        any_invalid_s = ~(&valid_q[idx_s]);
        // Scan downwards so the lowest-numbered way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match_s[w]) begin
                hit_way_s = WAY_W'(w);
            end else begin
                hit_way_s = hit_way_s;
            end
            if (!valid_q[idx_s][w]) begin
                inv_way_s = WAY_W'(w);
            end else begin
                inv_way_s = inv_way_s;
            end
        end
        line_s = data_mem[idx_s][hit_way_s];
        for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
            if (off_s == OFF_W'(i)) begin
                word_sel_s = line_s[i*WORD_WIDTH +: WORD_WIDTH];
            end else begin
                word_sel_s = word_sel_s;
            end
        end
        // Misses return zero rather than whatever stale line the index selects.
        if (hit_s) begin
            rd_word_s = word_sel_s;
        end else begin
            rd_word_s = '0;
        end
    end

    // Fill target priority (matching way, free way, victim) and the way the shared PLRU marks.
    always_comb begin
        if (hit_s) begin
            fill_way_s = hit_way_s;
        end else if (any_invalid_s) begin
            fill_way_s = inv_way_s;
        end else begin
            fill_way_s = victim_s;
        end
        // Read and write share one address, so a write always owns the set's PLRU update.
        if (wr_accept_s) begin
            access_way_s = fill_way_s;
        end else begin
            access_way_s = hit_way_s;
        end
    end

    icache_plru #(
        .WAYS (WAYS)
    ) u_plru (
        .plru_bits  (plru_q[idx_s]),
        .access_way (access_way_s),
        .plru_next  (plru_upd_s),
        .victim_way (victim_s)
    );

    // Next-state for the flush sequencer, valid bits and PLRU trees.
    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        valid_d     = valid_q;
        plru_d      = plru_q;
        case (state_q)
            IDLE: begin
                if (wr_accept_s) begin
                    valid_d[idx_s][fill_way_s] = 1'b1;
                    plru_d[idx_s]              = plru_upd_s;
                end else if (rd_accept_s && hit_s) begin
                    plru_d[idx_s] = plru_upd_s;
                end else begin
                    plru_d[idx_s] = plru_q[idx_s];
                end
                if (flush_accept_s) begin
                    state_d     = SWEEP;
                    sweep_cnt_d = '0;
                end else begin
                    state_d     = IDLE;
                end
            end
            SWEEP: begin
                valid_d[sweep_cnt_q] = '0;
                plru_d[sweep_cnt_q]  = '0;
                if (sweep_cnt_q == INDEX_BITS'(NUM_SETS - 1)) begin
                    state_d     = IDLE;
                    sweep_cnt_d = '0;
                end else begin
                    sweep_cnt_d = sweep_cnt_q + INDEX_BITS'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                sweep_cnt_d = '0;
            end
        endcase
    end

    // Sequencer, valid and PLRU registers; reset aborts any sweep.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sweep_cnt_q <= '0;
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
            valid_q     <= valid_d;
            plru_q      <= plru_d;
        end
    end

    // Tag and data arrays, written only by accepted fills.
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            tag_mem[idx_s][fill_way_s]  <= tag_s;
            data_mem[idx_s][fill_way_s] <= write_block;
        end
    end

    // Lookup result registers; hit/data/way hold until the next accepted read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_valid_q <= 1'b0;
            hit_q        <= 1'b0;
            read_data_q  <= '0;
            hit_way_q    <= '0;
        end else begin
            read_valid_q <= rd_accept_s;
            if (rd_accept_s) begin
                hit_q       <= hit_s;
                read_data_q <= rd_word_s;
                hit_way_q   <= hit_way_s;
            end
        end
    end

    assign read_valid = read_valid_q;
    assign hit        = hit_q;
    assign read_data  = read_data_q;
    assign hit_way    = hit_way_q;
    assign busy       = (state_q == SWEEP);

endmodule

// File: tb/tb_icache_sa_storage.sv
// ----------------------------------------------------------------------------
// tb_icache_sa_storage
// Directed bench for icache_sa_storage with WAYS=2, BLOCK_SIZE=4,
// INDEX_BITS=4, 32-bit words and addresses. Address 0x10 is tag 0, set 4,
// offset 0; 0x50 / 0x90 are tags 1 / 2 of the same set.
// ----------------------------------------------------------------------------
module tb_icache_sa_storage;

    logic          clk;
    logic          reset_n;
    logic          read;
    logic          write;
    logic [31:0]   address;
    logic [127:0]  write_block;
    logic          flush;
    logic          read_valid;
    logic          hit;
    logic [31:0]   read_data;
    logic [0:0]    hit_way;
    logic          busy;

    int errors;
    int checks;

    icache_sa_storage #(
        .WAYS       (2),
        .BLOCK_SIZE (4),
        .WORD_WIDTH (32),
        .INDEX_BITS (4),
        .ADDR_WIDTH (32)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .read        (read),
        .write       (write),
        .address     (address),
        .write_block (write_block),
        .flush       (flush),
        .read_valid  (read_valid),
        .hit         (hit),
        .read_data   (read_data),
        .hit_way     (hit_way),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [127:0] blk);
        @(negedge clk);
        write       = 1'b1;
        address     = addr;
        write_block = blk;
        @(posedge clk);
        #1;
        write = 1'b0;
    endtask

    task automatic chk_read(input string tag, input logic [31:0] addr, input logic exp_hit,
                            input logic [31:0] exp_data, input logic exp_way);
        @(negedge clk);
        read    = 1'b1;
        address = addr;
        @(posedge clk);
        #1;
        read = 1'b0;
        chk({tag, "_rv"},   32'(read_valid), 32'd1);
        chk({tag, "_hit"},  32'(hit),        32'(exp_hit));
        chk({tag, "_data"}, read_data,       exp_data);
        chk({tag, "_way"},  32'(hit_way),    32'(exp_way));
    endtask

    // Pulse flush, count busy cycles (bounded) and try a read during the sweep.
    task automatic flush_and_count(input string tag);
        int busy_cycles;
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk({tag, "_busy_start"}, 32'(busy), 32'd1);
        busy_cycles = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            read    = (i == 2);
            address = 32'h0000_0010;
            @(posedge clk);
            #1;
            read = 1'b0;
            if (i == 2) begin
                chk({tag, "_rv_while_busy"}, 32'(read_valid), 32'd0);
            end
            if (busy) begin
                busy_cycles++;
            end else begin
                break;
            end
        end
        chk({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd16);
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        reset_n     = 1'b0;
        read        = 1'b0;
        write       = 1'b0;
        flush       = 1'b0;
        address     = 32'h0;
        write_block = 128'h0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rv",   32'(read_valid), 32'd0);
        chk("rst_hit",  32'(hit),        32'd0);
        chk("rst_data", read_data,       32'd0);
        chk("rst_way",  32'(hit_way),    32'd0);
        chk("rst_busy", 32'(busy),       32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Cold miss, then read_valid is a single-cycle pulse.
        chk_read("cold", 32'h0000_0010, 1'b0, 32'd0, 1'b0);
        @(posedge clk);
        #1;
        chk("cold_rv_drop", 32'(read_valid), 32'd0);

        // Fill A, read word 2.
        do_write(32'h0000_0010, {32'd4, 32'd3, 32'd2, 32'd1});
        chk_read("hitA", 32'h0000_0012, 1'b1, 32'd3, 1'b0);

        // Fill B into the free way, touch A, fill C: B is the victim.
        do_write(32'h0000_0050, {32'd14, 32'd13, 32'd12, 32'd11});
        chk_read("touchA", 32'h0000_0011, 1'b1, 32'd2, 1'b0);
        do_write(32'h0000_0090, {32'd24, 32'd23, 32'd22, 32'd21});
        chk_read("missB", 32'h0000_0050, 1'b0, 32'd0, 1'b0);
        chk_read("hitC",  32'h0000_0092, 1'b1, 32'd23, 1'b1);
        chk_read("hitA2", 32'h0000_0010, 1'b1, 32'd1, 1'b0);

        // Refill A with new data: the same way is overwritten, C survives.
        do_write(32'h0000_0010, {32'd8, 32'd7, 32'd6, 32'd5});
        chk_read("refillA", 32'h0000_0013, 1'b1, 32'd8, 1'b0);
        chk_read("keepC",   32'h0000_0090, 1'b1, 32'd21, 1'b1);

        // Read and write to the same address in one cycle: lookup sees old contents.
        @(negedge clk);
        read        = 1'b1;
        write       = 1'b1;
        address     = 32'h0000_0024;
        write_block = {32'd34, 32'd33, 32'd32, 32'd31};
        @(posedge clk);
        #1;
        read  = 1'b0;
        write = 1'b0;
        chk("rw_rv",   32'(read_valid), 32'd1);
        chk("rw_hit",  32'(hit),        32'd0);
        chk("rw_data", read_data,       32'd0);
        chk_read("rw_after", 32'h0000_0025, 1'b1, 32'd32, 1'b0);
        @(posedge clk);
        #1;
        chk("hold_rv",   32'(read_valid), 32'd0);
        chk("hold_data", read_data,       32'd32);
        chk("hold_hit",  32'(hit),        32'd1);

        // Full flush: 16 busy cycles, everything misses afterwards.
        flush_and_count("flush1");
        chk_read("fl_missA", 32'h0000_0010, 1'b0, 32'd0, 1'b0);
        chk_read("fl_missC", 32'h0000_0090, 1'b0, 32'd0, 1'b0);
        chk_read("fl_missE", 32'h0000_0024, 1'b0, 32'd0, 1'b0);

        // Read together with flush: the read completes, then the sweep runs.
        do_write(32'h0000_0010, {32'd8, 32'd7, 32'd6, 32'd5});
        @(negedge clk);
        read    = 1'b1;
        flush   = 1'b1;
        address = 32'h0000_0011;
        @(posedge clk);
        #1;
        read  = 1'b0;
        flush = 1'b0;
        chk("rf_rv",   32'(read_valid), 32'd1);
        chk("rf_hit",  32'(hit),        32'd1);
        chk("rf_data", read_data,       32'd6);
        chk("rf_busy", 32'(busy),       32'd1);

        // Abort the sweep with reset part way through.
        repeat (5) @(posedge clk);
        #1;
        chk("abort_busy_pre", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy),      32'd0);
        chk("abort_hit",  32'(hit),       32'd0);
        chk("abort_data", read_data,      32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        chk_read("post_rst_miss", 32'h0000_0010, 1'b0, 32'd0, 1'b0);
        flush_and_count("flush2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache_sa_storage.md
# icache_sa_storage

Parametrised N-way set-associative tag/data store for the instruction cache, the successor to the direct-mapped storage block. It sits between the icache controller and the CPU fetch port. It provides registered hit/miss lookup, fill with tree-PLRU victim selection, and a sequenced whole-cache flush. All miss handling and memory traffic stay in the controller.

## Interface
- WAYS, 2, associativity; power of two, 1..8
- BLOCK_SIZE, 4, words per line; power of two, ≥1
- WORD_WIDTH, 32, instruction width
- INDEX_BITS, 4, set index width; NUM_SETS = 2^INDEX_BITS
- ADDR_WIDTH, 32, word address width
- Derived (localparam): OFFSET_BITS = clog2(BLOCK_SIZE), or 0 when BLOCK_SIZE = 1; TAG_BITS = ADDR_WIDTH − INDEX_BITS − OFFSET_BITS

Ports:
- clk  in  1  single clock; all logic on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- read  in  1  lookup request
- write  in  1  line fill request
- address  in  ADDR_WIDTH  word address, split as {tag, index, offset}
- write_block  in  WORD_WIDTH*BLOCK_SIZE  fill line; word i at bits [i*WORD_WIDTH +: WORD_WIDTH]
- flush  in  1  invalidate-all request (one-cycle pulse)
- read_valid  out  1  one-cycle pulse: lookup result is valid
- hit  out  1  lookup result
- read_data  out  WORD_WIDTH  hit word
- hit_way  out  clog2(WAYS), min 1  way that hit
- busy  out  1  flush in progress

## Operation
- Lookup
  - An accepted read compares the tag against all ways of set `index` in parallel.
  - Hit: a valid way with matching tag.
  - On hit: the set's PLRU is updated to mark that way most-recent.
  - On miss: read_data = 0 (never X) and the PLRU is unchanged.
- Fill
  - An accepted write first checks the set for a valid way with matching tag and overwrites that way if found (no duplicates).
  - Otherwise it fills the lowest-numbered invalid way.
  - Otherwise it fills the PLRU victim.
  - In all cases it sets valid, writes the tag and all BLOCK_SIZE words, and marks the way most-recent.
- Read and write in the same cycle
  - Both are accepted.
  - The lookup sees the pre-write contents.
  - If they target the same set, only the write's PLRU update is applied.
- PLRU: tree of WAYS−1 bits per set. When WAYS = 1 there is no state and the victim is way 0.
- Flush
  - While idle, flush starts a sweep that clears the valid bits and PLRU of set 0..NUM_SETS−1, one set per cycle.
  - Tags and data are not cleared.
- While busy
  - read, write and flush are ignored.
  - No read_valid is produced and no state changes except the sweep.
- Reset (reset_n low)
  - All valid bits = 0 and all PLRU bits = 0.
  - read_valid = 0, hit = 0, read_data = 0, hit_way = 0, busy = 0.
  - A flush in progress is aborted.
  - Tag and data arrays are not reset.

## Timing
- Lookup latency is 1 cycle: read accepted at edge N → read_valid = 1 for one cycle after N with hit, read_data and hit_way. Those three hold their values until the next accepted read.
- A write at edge N is visible to a read accepted at edge N+1.
- Flush
  - flush sampled at edge N → busy = 1 from after N.
  - Set k is cleared at edge N+1+k.
  - busy drops after edge N+NUM_SETS, so it is high for exactly NUM_SETS cycles.
  - A read at edge N+NUM_SETS+1 is accepted.
- flush sampled together with read or write at the same edge: the read/write is accepted, its result is produced normally, then the sweep begins.
- Reset deassertion is synchronised by the system. The block requires no idle cycles after it.

## Structure
- Shared package icache_pkg holds:
  - the address-split helper functions (offset, index, tag extraction given parameters)
  - the PLRU bit-layout constants
  - the flush-state encoding (IDLE, SWEEP)
- The state machine is two states: IDLE → SWEEP on flush. SWEEP → IDLE when the sweep counter reaches NUM_SETS−1.
- Sub-module icache_plru (parameter WAYS): combinational
  - inputs: the set's PLRU bits and an access-way
  - outputs: the updated bits and the victim way
  - instantiated once for lookup/fill, shared by a priority mux.

## Test plan
- Reset, then read at address 0x0000_0010 → read_valid pulse next cycle, hit = 0, read_data = 0.
- WAYS = 2: write line {4,3,2,1} at 0x0000_0010, then read 0x0000_0012 → hit = 1, read_data = 3, hit_way = 0.
- WAYS = 2, same set: fill tags A, B, read A, fill C → C replaces B. Read B misses; read A hits with hit_way = 0.
- Refill an existing tag A with new data → same way overwritten, no second copy. Subsequent read returns the new word.
- Flush with INDEX_BITS = 4 → busy high exactly 16 cycles. A read during busy produces no read_valid. All previously filled lines miss afterwards.
- Pull reset_n low at sweep cycle 5 → busy = 0 immediately. After release, reads miss and a new flush sweeps a full 16 cycles.
